// File: rtl/ramasync_pkg.sv
// Shared types and helpers for the multi-port async-read RAM.
// The lane merge is used by both the array write path and the read bypass.
package ramasync_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam int LANEW = 8;

    function automatic logic [LANEW-1:0] lane_merge(
        input logic [LANEW-1:0] old_b,
        input logic [LANEW-1:0] new_b,
        input logic             en
    );
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/ramasync_rdport.sv
// One read port: address mux, busy zero-force, optional output register
// with optional same-cycle write bypass.
module ramasync_rdport
    import ramasync_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 6,
    parameter int REGOUT = 0,
    parameter int BYPASS = 1
) (
    input  logic                    i_clk,
    input  logic                    i_nreset,
    input  logic                    i_busy,
    input  logic                    i_we,
    input  logic [DW/LANEW-1:0]     i_wmask,
    input  logic [AW-1:0]           i_waddr,
    input  logic [DW-1:0]           i_din,
    input  logic [AW-1:0]           i_raddr,
    input  logic [DW*(2**AW)-1:0]   i_mem,
    output logic [DW-1:0]           o_dout
);

    logic [DW-1:0] w_old;
    assign w_old = i_mem[i_raddr*DW +: DW];

    // Some configurations leave write-side inputs unused.
    logic w_unused;
    assign w_unused = &{1'b0, i_clk, i_nreset, i_we, i_wmask, i_waddr, i_din};

    generate
        if (REGOUT == 0) begin : g_comb
            assign o_dout = i_busy ? '0 : w_old;
        end else begin : g_reg
            logic [DW-1:0] w_merge;
            logic          w_hit;
            logic [DW-1:0] r_dout;

            always_comb begin
                w_merge = '0;
                for (int l = 0; l < DW/LANEW; l++) begin
                    w_merge[l*LANEW +: LANEW] = lane_merge(w_old[l*LANEW +: LANEW],
                                                           i_din[l*LANEW +: LANEW],
                                                           i_wmask[l]);
                end
            end

            assign w_hit = (BYPASS != 0) && i_we && (i_waddr == i_raddr);

            always_ff @(posedge i_clk or negedge i_nreset) begin
                if (!i_nreset) begin
                    r_dout <= '0;
                end else if (i_busy) begin
                    r_dout <= '0;
                end else if (w_hit) begin
                    r_dout <= w_merge;
                end else begin
                    r_dout <= w_old;
                end
            end

            assign o_dout = r_dout;
        end
    endgenerate

endmodule

// File: rtl/ramasync_mp.sv
// Multi-port distributed RAM: byte-masked write port, NR read ports and a
// clear sequencer that zero-fills the array after reset or on request.
//
// state    | meaning
// ST_CLEAR | writing zero to mem[r_cnt] each cycle, user writes dropped
// ST_IDLE  | normal read/write operation
module ramasync_mp
    import ramasync_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 6,
    parameter int NR     = 2,
    parameter int REGOUT = 0,
    parameter int BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 clear,
    output logic                 busy,
    input  logic                 we,
    input  logic [DW/LANEW-1:0]  wmask,
    input  logic [AW-1:0]        waddr,
    input  logic [DW-1:0]        din,
    output logic                 werr,
    input  logic [NR*AW-1:0]     raddr,
    output logic [NR*DW-1:0]     dout
);

    localparam int             DEPTH    = 2**AW;
    localparam logic [AW-1:0]  CNT_LAST = AW'(DEPTH-1);

    state_t              r_state;
    logic [AW-1:0]       r_cnt;
    logic                r_busy;
    logic                r_werr;
    logic [DW-1:0]       r_mem [DEPTH];
    logic [DW-1:0]       w_wmerge;
    logic [DW*DEPTH-1:0] w_mem_flat;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_werr  <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_werr <= we;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    r_werr <= 1'b0;
                    if (clear) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_werr  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign werr = r_werr;

    always_comb begin
        w_wmerge = '0;
        for (int l = 0; l < DW/LANEW; l++) begin
            w_wmerge[l*LANEW +: LANEW] = lane_merge(r_mem[waddr][l*LANEW +: LANEW],
                                                    din[l*LANEW +: LANEW],
                                                    wmask[l]);
        end
    end

    // Clear data always wins over a user write.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else if (we) begin
            r_mem[waddr] <= w_wmerge;
        end
    end

    always_comb begin
        w_mem_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_mem_flat[i*DW +: DW] = r_mem[i];
        end
    end

    generate
        for (genvar k = 0; k < NR; k++) begin : g_rd
            ramasync_rdport #(
                .DW     (DW),
                .AW     (AW),
                .REGOUT (REGOUT),
                .BYPASS (BYPASS)
            ) u_rd (
                .i_clk    (clk),
                .i_nreset (nreset),
                .i_busy   (r_busy),
                .i_we     (we),
                .i_wmask  (wmask),
                .i_waddr  (waddr),
                .i_din    (din),
                .i_raddr  (raddr[k*AW +: AW]),
                .i_mem    (w_mem_flat),
                .o_dout   (dout[k*DW +: DW])
            );
        end
    endgenerate

endmodule
